header_padder: RTL and testbench

Producer side of the SHA-256 message path. Accepts a block header as a stream of 32-bit words and builds the two-block padded message (1024 bits: header, 0x80 marker, zero fill, 64-bit bit-length). It presents the result on a valid/ready output to the message-schedule/compression block. It can also emit a sweep of messages, incrementing the nonce word each time, so the hashing core can be fed back-to-back without reloading the header.

---
 rtl/sha_pkg.sv | 21 ++
 rtl/header_padder.sv | 89 ++++++++
 tb/tb_header_padder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sha_pkg.sv
// Shared SHA-256 message-path definitions: sizes, padding constants and the
// padder's state encoding.
package sha_pkg;

  localparam int          SHA_BLOCK_BITS = 512;
  localparam int          SHA_MSG_BITS   = 1024;
  localparam logic [31:0] SHA_PAD_MARKER = 32'h8000_0000;

  typedef enum logic {LOAD, EMIT} pad_state_t;

  // Constant padding word at a word index past the header: marker, zero fill,
  // then the 64-bit bit-length whose upper half (word 30) is always zero.
  function automatic logic [31:0] pad_word(input int index, input int header_words);
    logic [31:0] w;
    w = '0;
    if (index == header_words) w = SHA_PAD_MARKER;
    else if (index == 31)      w = header_words * 32;
    return w;
  endfunction

endpackage

// File: rtl/header_padder.sv
// Builds the two-block padded SHA-256 message from a streamed header and
// emits a nonce sweep of messages on a valid/ready output.
module header_padder
  import sha_pkg::*;
#(
  parameter int HEADER_WORDS = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_data,
  input  logic [15:0]             sweep_count,
  output logic [SHA_MSG_BITS-1:0] message,
  output logic                    msg_valid,
  input  logic                    msg_ready,
  output logic                    busy,
  output logic                    done
);

  localparam logic [4:0] LAST_IDX = 5'(HEADER_WORDS - 1);
  localparam int         NONCE_HI = SHA_MSG_BITS - 1 - 32 * (HEADER_WORDS - 1);

  pad_state_t  state, state_nx;
  logic [4:0]  idx;
  logic [15:0] remaining;
  logic        accept, last_word, hshake, final_hs;

  assign in_ready  = (state == LOAD);
  assign msg_valid = (state == EMIT);
  assign accept    = in_ready & in_valid;
  assign last_word = accept & (idx == LAST_IDX);
  assign hshake    = msg_valid & msg_ready;
  assign final_hs  = hshake & (remaining == 16'd1);

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (last_word) state_nx = EMIT;
      EMIT:    if (final_hs)  state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD;
    else      state <= state_nx;
  end

  // The message register doubles as the header word store; padding words are
  // written once as the last header word lands so they are stable in EMIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      message <= '0;
    end else if (accept) begin
      message[SHA_MSG_BITS-1-32*int'(idx) -: 32] <= in_data;
      if (last_word)
        for (int k = HEADER_WORDS; k < 32; k++)
          message[SHA_MSG_BITS-1-32*k -: 32] <= pad_word(k, HEADER_WORDS);
    end else if (hshake && !final_hs) begin
      message[NONCE_HI -: 32] <= message[NONCE_HI -: 32] + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= final_hs;
      if (accept) begin
        idx <= last_word ? 5'd0 : idx + 5'd1;
        if (idx == 5'd0) begin
          remaining <= (sweep_count == 16'd0) ? 16'd1 : sweep_count;
          busy      <= 1'b1;
        end
      end else if (final_hs) begin
        idx       <= '0;
        remaining <= '0;
        busy      <= 1'b0;
      end else if (hshake) begin
        remaining <= remaining - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_header_padder.sv
// Randomized self-checking bench for header_padder against a word-level
// model of the padded message and sweep sequencing.
module tb_header_padder;
  localparam int HW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = '0;
  logic [15:0]   sweep_count = '0;
  logic [1023:0] message;
  logic          msg_valid;
  logic          msg_ready = 1'b0;
  logic          busy;
  logic          done;

  header_padder #(.HEADER_WORDS(HW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sweep_count(sweep_count), .message(message),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] hdr [HW];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected word k of the n-th message of a sweep over the current header.
  function automatic logic [31:0] exp_word(input int k, input int n);
    if (k < HW - 1) return hdr[k];
    if (k == HW - 1) return hdr[k] + 32'(n);
    if (k == HW) return 32'h8000_0000;
    if (k == 31) return 32'(HW * 32);
    return 32'h0;
  endfunction

  task automatic check_msg(input int n);
    for (int k = 0; k < 32; k++)
      chk($sformatf("msg%0d w%0d", n, k), message[1023-32*k -: 32], exp_word(k, n));
  endtask

  task automatic reset_checks();
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst msg_valid", 32'(msg_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    for (int k = 0; k < 32; k++)
      chk($sformatf("rst msg w%0d", k), message[1023-32*k -: 32], 32'h0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; msg_ready = 1'b0;
    #1 reset_checks();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Drives the first nwords header words; gaps inserts an idle cycle before each word.
  task automatic load(input logic [15:0] sc, input bit gaps, input int nwords, input bit now);
    for (int i = 0; i < nwords; i++) begin
      if (!(i == 0 && now)) @(negedge clk);
      if (gaps && i > 0) begin
        in_valid = 1'b0; in_data = $urandom;
        @(negedge clk);
      end
      chk("load in_ready", 32'(in_ready), 32'd1);
      chk("load msg_valid", 32'(msg_valid), 32'd0);
      if (i > 0) chk("load busy", 32'(busy), 32'd1);
      in_valid = 1'b1;
      in_data = hdr[i];
      sweep_count = (i == 0) ? sc : 16'($urandom);
    end
  endtask

  // mode 0: ready always, 1: pattern 0,0,1,0,1, 2: random.
  task automatic emit(input int count, input int mode, input bit hold, input int abort_at);
    int n = 0;
    int cyc = 0;
    bit rdy;
    bit pat [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    while (n < count && cyc < 300) begin
      @(negedge clk);
      if (abort_at >= 0 && n == abort_at) begin
        rst = 1'b0; in_valid = 1'b0; msg_ready = 1'b0;
        #1 reset_checks();
        @(negedge clk);
        rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          chk("post-abort done", 32'(done), 32'd0);
          chk("post-abort busy", 32'(busy), 32'd0);
        end
        return;
      end
      chk("emit msg_valid", 32'(msg_valid), 32'd1);
      chk("emit in_ready", 32'(in_ready), 32'd0);
      chk("emit busy", 32'(busy), 32'd1);
      chk("emit done", 32'(done), 32'd0);
      check_msg(n);
      in_valid = hold;
      in_data = $urandom;
      case (mode)
        0: rdy = 1'b1;
        1: rdy = pat[cyc % 5];
        default: rdy = 1'($urandom);
      endcase
      msg_ready = rdy;
      if (rdy) n++;
      if (n == count) in_valid = 1'b0;
      cyc++;
    end
    chk("emit timeout", 32'(cyc < 300), 32'd1);
    @(negedge clk);
    msg_ready = 1'b0;
    chk("done pulse", 32'(done), 32'd1);
    chk("done busy", 32'(busy), 32'd0);
    chk("done in_ready", 32'(in_ready), 32'd1);
    chk("done msg_valid", 32'(msg_valid), 32'd0);
  endtask

  initial begin
    int sc;
    int eff;
    repeat (2) @(negedge clk);
    reset_checks();
    rst = 1'b1;

    // Incrementing header, single message.
    for (int k = 0; k < HW; k++) hdr[k] = 32'(k + 1);
    load(16'd1, 1'b0, HW, 1'b0);
    emit(1, 0, 1'b0, -1);

    // Same header, sweep of four; next header starts in the done cycle.
    load(16'd4, 1'b0, HW, 1'b0);
    emit(4, 0, 1'b0, -1);

    // Nonce wraps through zero.
    for (int k = 0; k < HW; k++) hdr[k] = $urandom;
    hdr[HW-1] = 32'hFFFF_FFFE;
    load(16'd3, 1'b0, HW, 1'b1);
    emit(3, 0, 1'b0, -1);

    // Stalls during a sweep of two.
    for (int k = 0; k < HW; k++) hdr[k] = $urandom;
    load(16'd2, 1'b0, HW, 1'b0);
    emit(2, 1, 1'b0, -1);

    // Gapped load, in_valid held during EMIT, sweep_count 0 means one.
    for (int k = 0; k < HW; k++) hdr[k] = $urandom;
    load(16'd0, 1'b1, HW, 1'b0);
    emit(1, 0, 1'b1, -1);
    for (int k = 0; k < HW; k++) hdr[k] = $urandom;
    load(16'd3, 1'b1, HW, 1'b0);
    emit(3, 2, 1'b1, -1);

    // Reset mid-load, then mid-sweep, then a clean load.
    for (int k = 0; k < HW; k++) hdr[k] = $urandom;
    load(16'd2, 1'b0, 10, 1'b0);
    pulse_reset();
    for (int k = 0; k < HW; k++) hdr[k] = $urandom;
    load(16'd5, 1'b0, HW, 1'b0);
    emit(5, 0, 1'b0, 2);
    for (int k = 0; k < HW; k++) hdr[k] = $urandom;
    load(16'd2, 1'b0, HW, 1'b0);
    emit(2, 2, 1'b0, -1);

    // Random headers, sweep lengths and backpressure.
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < HW; k++) hdr[k] = $urandom;
      if (t % 3 == 0) hdr[HW-1] = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      sc = $urandom_range(0, 6);
      eff = (sc == 0) ? 1 : sc;
      load(16'(sc), 1'($urandom), HW, 1'b0);
      emit(eff, 2, 1'($urandom), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
